// File: rtl/geriyaz_hakem.sv
// geriyaz_hakem: round-robin writeback arbiter over per-source result FIFOs
module geriyaz_hakem #(
  parameter int KAYNAK_SAYISI = 3,
  parameter int DERINLIK      = 2,
  parameter int VERI_BIT      = 32,
  parameter int YAZMAC_BIT    = 5,
  parameter int ETIKET_BIT    = 6
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [KAYNAK_SAYISI*VERI_BIT-1:0]   kaynak_veri_i,
  input  logic [KAYNAK_SAYISI*YAZMAC_BIT-1:0] kaynak_adres_i,
  input  logic [KAYNAK_SAYISI*ETIKET_BIT-1:0] kaynak_etiket_i,
  input  logic [KAYNAK_SAYISI-1:0]            kaynak_gecerli_i,
  output logic [KAYNAK_SAYISI-1:0]            kaynak_hazir_o,
  input  logic                                bosalt_i,
  output logic [VERI_BIT-1:0]                 geriyaz_veri_o,
  output logic [YAZMAC_BIT-1:0]               geriyaz_adres_o,
  output logic [ETIKET_BIT-1:0]               geriyaz_etiket_o,
  output logic                                geriyaz_gecerli_o
);
  localparam int K  = KAYNAK_SAYISI;
  localparam int EW = VERI_BIT + YAZMAC_BIT + ETIKET_BIT;
  localparam int AW = $clog2(DERINLIK);
  localparam int CW = $clog2(DERINLIK + 1);
  localparam int PW = (K > 1) ? $clog2(K) : 1;
  logic [EW-1:0] mem [K][DERINLIK];
  logic [AW-1:0] rd_ptr [K];
  logic [AW-1:0] wr_ptr [K];
  logic [CW-1:0] cnt [K];
  logic [CW-1:0] cnt_n [K];
  logic [K-1:0]  push, pop, hazir_n;
  logic [PW-1:0] rr, winner, idx;
  logic [PW:0]   sum;
  logic          found;
  logic [EW-1:0] head;
  // pick the first non-empty FIFO at or after the round-robin pointer
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < K; i++) begin
      sum = {1'b0, rr} + (PW+1)'(i);
      idx = (sum >= (PW+1)'(K)) ? PW'(sum - (PW+1)'(K)) : PW'(sum);
      if (!found && cnt[idx] != '0) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end
  // per-source push/pop and next occupancy; ready is granted only on next-cycle room
  always_comb begin
    for (int k = 0; k < K; k++) begin
      push[k]    = kaynak_gecerli_i[k] & kaynak_hazir_o[k] & ~bosalt_i;
      pop[k]     = found && winner == PW'(k);
      cnt_n[k]   = cnt[k] + CW'(push[k]) - CW'(pop[k]);
      hazir_n[k] = cnt_n[k] < CW'(DERINLIK);
    end
    head = mem[winner][rd_ptr[winner]];
  end
  // FIFO storage needs no reset; occupancy is tracked by the counters
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < K; k++)
      if (push[k])
        mem[k][wr_ptr[k]] <= {kaynak_veri_i[k*VERI_BIT +: VERI_BIT],
                              kaynak_adres_i[k*YAZMAC_BIT +: YAZMAC_BIT],
                              kaynak_etiket_i[k*ETIKET_BIT +: ETIKET_BIT]};
  end
  // FIFO pointers, counts, ready flags and round-robin pointer; flush clears everything
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < K; k++) begin
        cnt[k]    <= '0;
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
      end
      kaynak_hazir_o <= '0;
      rr             <= '0;
    end else if (bosalt_i) begin
      for (int k = 0; k < K; k++) begin
        cnt[k]    <= '0;
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
      end
      kaynak_hazir_o <= '1;
      rr             <= '0;
    end else begin
      for (int k = 0; k < K; k++) begin
        cnt[k]    <= cnt_n[k];
        rd_ptr[k] <= pop[k] ? rd_ptr[k] + AW'(1) : rd_ptr[k];
        wr_ptr[k] <= push[k] ? wr_ptr[k] + AW'(1) : wr_ptr[k];
      end
      kaynak_hazir_o <= hazir_n;
      if (found)
        rr <= (winner == PW'(K-1)) ? '0 : winner + PW'(1);
    end
  end
  // writeback register: strobe only for popped entries targeting a real register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      geriyaz_veri_o    <= '0;
      geriyaz_adres_o   <= '0;
      geriyaz_etiket_o  <= '0;
      geriyaz_gecerli_o <= 1'b0;
    end else if (bosalt_i || !found) begin
      geriyaz_gecerli_o <= 1'b0;
    end else begin
      geriyaz_veri_o    <= head[EW-1 -: VERI_BIT];
      geriyaz_adres_o   <= head[ETIKET_BIT +: YAZMAC_BIT];
      geriyaz_etiket_o  <= head[ETIKET_BIT-1:0];
      geriyaz_gecerli_o <= head[ETIKET_BIT +: YAZMAC_BIT] != '0;
    end
  end
endmodule

// File: tb/tb_geriyaz_hakem.sv
// tb_geriyaz_hakem: randomized and directed checks against a queue-based reference model
module tb_geriyaz_hakem;
  typedef struct {
    logic [31:0] v;
    logic [4:0]  a;
    logic [5:0]  t;
  } ent_t;
  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        bosalt = 1'b0;
  logic [2:0]  vld = '0;
  logic [31:0] pv [3];
  logic [4:0]  pa [3];
  logic [5:0]  pt [3];
  logic [3:0]  seq [3];
  logic [95:0] kv;
  logic [14:0] ka;
  logic [17:0] kt;
  logic [2:0]  hz;
  logic [31:0] gv;
  logic [4:0]  ga;
  logic [5:0]  gt;
  logic        gg;
  ent_t        q [3][$];
  int          m_rr;
  logic [2:0]  m_hz;
  logic [2:0]  acc;
  logic        e_g;
  ent_t        e_w;
  int          pass_n = 0;
  int          total_n = 0;
  assign kv = {pv[2], pv[1], pv[0]};
  assign ka = {pa[2], pa[1], pa[0]};
  assign kt = {pt[2], pt[1], pt[0]};
  always #5 clk_i = ~clk_i;
  geriyaz_hakem dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .kaynak_veri_i(kv), .kaynak_adres_i(ka), .kaynak_etiket_i(kt),
    .kaynak_gecerli_i(vld), .kaynak_hazir_o(hz), .bosalt_i(bosalt),
    .geriyaz_veri_o(gv), .geriyaz_adres_o(ga), .geriyaz_etiket_o(gt),
    .geriyaz_gecerli_o(gg)
  );
  task automatic new_pay(input int k, input logic zero_ok);
    seq[k] = seq[k] + 4'd1;
    pv[k]  = $urandom;
    pa[k]  = (zero_ok && $urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    pt[k]  = {2'(k), seq[k]};
  endtask
  task automatic model_clear();
    for (int k = 0; k < 3; k++) q[k].delete();
    m_rr = 0;
  endtask
  task automatic do_reset();
    rstn_i = 1'b0;
    vld = '0;
    bosalt = 1'b0;
    model_clear();
    m_hz = '0;
    e_g = 1'b0;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      seq[k] = '0;
      new_pay(k, 1'b0);
    end
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
  endtask
  task automatic step();
    ent_t w;
    int win;
    acc = bosalt ? 3'b000 : (vld & m_hz);
    if (bosalt) begin
      model_clear();
      e_g = 1'b0;
      m_hz = 3'b111;
    end else begin
      win = -1;
      for (int i = 0; i < 3; i++)
        if (win < 0 && q[(m_rr + i) % 3].size() > 0) win = (m_rr + i) % 3;
      e_g = 1'b0;
      if (win >= 0) begin
        w = q[win].pop_front();
        e_g = w.a != 0;
        if (e_g) e_w = w;
        m_rr = (win + 1) % 3;
      end
      for (int k = 0; k < 3; k++) if (acc[k]) q[k].push_back('{pv[k], pa[k], pt[k]});
      for (int k = 0; k < 3; k++) m_hz[k] = q[k].size() < 2;
    end
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset();
    rstn_i = 1'b0;
    #1;
    total_n++;
    if ({hz, gg, gv, ga, gt} !== '0) $display("FAIL reset_outputs got %h want 0", {hz, gg, gv, ga, gt}); else pass_n++;
    do_reset();
    step();
    total_n++;
    if (hz !== 3'b111) $display("FAIL reset_release_hazir got %b want 111", hz); else pass_n++;
  endtask
  task automatic test_single();
    int hits = 0;
    do_reset();
    pv[0] = 32'hDEADBEEF; pa[0] = 5'd5; pt[0] = 6'd3;
    step();
    vld = 3'b001;
    step();
    vld = 3'b000;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        total_n++;
        if ({gg, gv, ga, gt} !== {1'b1, 32'hDEADBEEF, 5'd5, 6'd3})
          $display("FAIL single_latency got g=%b %h %0d %0d want 1 deadbeef 5 3", gg, gv, ga, gt);
        else pass_n++;
      end
      hits += int'(gg);
      step();
    end
    total_n++;
    if (hits != 1) $display("FAIL single_strobe_count got %0d want 1", hits); else pass_n++;
  endtask
  task automatic test_all_sources();
    int n = 0;
    do_reset();
    vld = 3'b111;
    for (int c = 0; c < 12; c++) begin
      step();
      for (int k = 0; k < 3; k++) if (acc[k]) new_pay(k, 1'b0);
      total_n += 2;
      if (hz !== m_hz) $display("FAIL all_hazir cyc %0d got %b want %b", c, hz, m_hz); else pass_n++;
      if (gg !== e_g) $display("FAIL all_gecerli cyc %0d got %b want %b", c, gg, e_g); else pass_n++;
      if (gg && n < 6) begin
        total_n++;
        if (gt[5:4] !== 2'(n % 3)) $display("FAIL all_order n=%0d got src %0d want %0d", n, gt[5:4], n % 3); else pass_n++;
        n++;
      end
    end
    vld = '0;
    total_n++;
    if (n != 6) $display("FAIL all_order_count got %0d want 6", n); else pass_n++;
  endtask
  task automatic test_zero_addr();
    int hits = 0;
    logic [4:0] seen = '0;
    do_reset();
    step();
    vld = 3'b010; pa[1] = 5'd0;
    step();
    pa[1] = 5'd7;
    step();
    vld = '0;
    for (int c = 0; c < 5; c++) begin
      total_n++;
      if (gg !== e_g) $display("FAIL zero_gecerli cyc %0d got %b want %b", c, gg, e_g); else pass_n++;
      if (gg) begin hits++; seen = ga; end
      step();
    end
    total_n++;
    if (hits != 1 || seen !== 5'd7) $display("FAIL zero_discard got %0d hits adres %0d want 1 hit adres 7", hits, seen); else pass_n++;
  endtask
  task automatic test_flush();
    do_reset();
    vld = 3'b111;
    for (int c = 0; c < 4; c++) begin
      step();
      for (int k = 0; k < 3; k++) if (acc[k]) new_pay(k, 1'b0);
    end
    total_n++;
    if (q[2].size() != 2 || hz[2] !== 1'b0) $display("FAIL flush_setup src2 got hazir %b want 0", hz[2]); else pass_n++;
    bosalt = 1'b1;
    step();
    bosalt = 1'b0;
    vld = '0;
    total_n++;
    if (hz !== 3'b111) $display("FAIL flush_hazir got %b want 111", hz); else pass_n++;
    for (int c = 0; c < 5; c++) begin
      total_n++;
      if (gg !== 1'b0) $display("FAIL flush_no_wb cyc %0d got %b want 0", c, gg); else pass_n++;
      step();
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    vld = 3'b111;
    for (int c = 0; c < 4; c++) begin
      step();
      for (int k = 0; k < 3; k++) if (acc[k]) new_pay(k, 1'b0);
    end
    #3 rstn_i = 1'b0;
    #1;
    total_n++;
    if ({hz, gg, gv, ga, gt} !== '0) $display("FAIL async_reset got %h want 0", {hz, gg, gv, ga, gt}); else pass_n++;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      total_n++;
      if (gg !== 1'b0 || gg !== e_g) $display("FAIL async_stale cyc %0d got %b want 0", c, gg); else pass_n++;
    end
  endtask
  task automatic test_full_pop();
    logic [2:0] want [6] = '{3'b111, 3'b111, 3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    vld = 3'b111;
    for (int c = 0; c < 6; c++) begin
      step();
      for (int k = 0; k < 3; k++) if (acc[k]) new_pay(k, 1'b0);
      total_n++;
      if (hz !== want[c]) $display("FAIL full_pop_hazir edge %0d got %b want %b", c + 1, hz, want[c]); else pass_n++;
    end
    vld = '0;
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bosalt = $urandom_range(0, 39) == 0;
      for (int k = 0; k < 3; k++) if (!vld[k]) vld[k] = $urandom_range(0, 2) != 0;
      step();
      for (int k = 0; k < 3; k++)
        if (acc[k]) begin
          new_pay(k, 1'b1);
          vld[k] = $urandom_range(0, 2) != 0;
        end
      total_n += 2;
      if (hz !== m_hz) $display("FAIL rand_hazir cyc %0d got %b want %b", c, hz, m_hz); else pass_n++;
      if (gg !== e_g) $display("FAIL rand_gecerli cyc %0d got %b want %b", c, gg, e_g); else pass_n++;
      if (e_g) begin
        total_n++;
        if ({gv, ga, gt} !== {e_w.v, e_w.a, e_w.t})
          $display("FAIL rand_data cyc %0d got %h/%0d/%h want %h/%0d/%h", c, gv, ga, gt, e_w.v, e_w.a, e_w.t);
        else pass_n++;
      end
    end
    bosalt = 1'b0;
    vld = '0;
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      seq[k] = '0;
      pv[k] = '0;
      pa[k] = '0;
      pt[k] = '0;
    end
    #2;
    test_reset();
    test_single();
    test_all_sources();
    test_zero_addr();
    test_flush();
    test_async_reset();
    test_full_pop();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
